// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: register-file write-port arbiter (WB vs MDU) with MDU scoreboard; `RF_SCHED_PERF_EN adds perf counters
module rf_wb_scheduler #(
    parameter int XLEN       = 32,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            mdu_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      A1,
    input  logic [4:0]      A2,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            stall_d,
    output logic            pipe_hold,
`ifdef RF_SCHED_PERF_EN
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_force_cnt,
`endif
    output logic [31:0]     busy_vec
);
    typedef enum logic {ARB, FORCE} state_t;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int SW = $clog2(STARVE_MAX) + 1;
    state_t          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     busy_q, busy_d;
    logic            wb_req, wb_sel, mdu_hs, blocked, issue_acc, starve_top;
    // Write-port mux, handshake, hazard detection and next-state computation
    always_comb begin
        wb_req     = RegWriteW && RdW != 5'd0;
        pipe_hold  = state_q == FORCE;
        mdu_ready  = pipe_hold || !wb_req;
        mdu_hs     = mdu_valid && mdu_ready;
        blocked    = mdu_valid && !mdu_ready;
        wb_sel     = !pipe_hold && wb_req;
        rf_we      = wb_sel || (mdu_hs && mdu_rd != 5'd0);
        rf_rd      = wb_sel ? RdW : mdu_rd;
        rf_wdata   = wb_sel ? ResultW : mdu_data;
        stall_d    = (A1 != 5'd0 && busy_q[A1]) || (A2 != 5'd0 && busy_q[A2]) ||
                     (issue_valid && issue_rd != 5'd0 && busy_q[issue_rd]) ||
                     (issue_valid && cnt_q == CW'(MAX_OUT));
        issue_acc  = issue_valid && !stall_d;
        busy_d     = busy_q;
        if (mdu_hs) busy_d[mdu_rd] = 1'b0;
        if (issue_acc) busy_d[issue_rd] = 1'b1;
        busy_d[0]  = 1'b0;
        cnt_d      = cnt_q + CW'(issue_acc) - CW'(mdu_hs && cnt_q != '0);
        starve_top = starve_q == SW'(STARVE_MAX - 1);
        starve_d   = (blocked && !starve_top) ? starve_q + 1'b1 : '0;
        state_d    = (blocked && starve_top) ? FORCE : ARB;
        busy_vec   = busy_q;
    end
    // Scheduler state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB;
            starve_q <= '0;
            cnt_q    <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end
`ifdef RF_SCHED_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_force_q, perf_force_d;
    // Saturating counters for stalled cycles and FORCE entries
    always_comb begin
        perf_stall_d   = perf_stall_q + 32'(stall_d && perf_stall_q != '1);
        perf_force_d   = perf_force_q + 32'(state_d == FORCE && perf_force_q != '1);
        perf_stall_cnt = perf_stall_q;
        perf_force_cnt = perf_force_q;
    end
    // Performance counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_force_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_force_q <= perf_force_d;
        end
    end
`endif
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed and randomized checks of rf_wb_scheduler against a behavioural model
module tb_rf_wb_scheduler;
    localparam int XLEN       = 32;
    localparam int MAX_OUT    = 4;
    localparam int STARVE_MAX = 4;
    logic            clk = 1'b0;
    logic            rst;
    logic            RegWriteW, mdu_valid, issue_valid, mdu_ready;
    logic [4:0]      RdW, mdu_rd, issue_rd, A1, A2, rf_rd;
    logic [XLEN-1:0] ResultW, mdu_data, rf_wdata;
    logic            rf_we, stall_d, pipe_hold;
    logic [31:0]     busy_vec;
`ifdef RF_SCHED_PERF_EN
    logic [31:0]     perf_stall_cnt, perf_force_cnt;
`endif
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [31:0]     m_busy;
    int              m_cnt, m_wait;
    bit              m_force, hs_last;
    logic [4:0]      pend_q[$];

    rf_wb_scheduler #(.XLEN(XLEN), .MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .A1(A1), .A2(A2),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .stall_d(stall_d), .pipe_hold(pipe_hold),
`ifdef RF_SCHED_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_force_cnt(perf_force_cnt),
`endif
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        RegWriteW = 0; RdW = 0; ResultW = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        issue_valid = 0; issue_rd = 0; A1 = 0; A2 = 0;
    endtask

    task automatic model_clear();
        m_busy = 0; m_cnt = 0; m_wait = 0; m_force = 0; hs_last = 0;
        pend_q.delete();
    endtask

    // Called at a falling edge with inputs set; checks outputs, then advances one cycle
    task automatic step();
        bit wb, rdy, stl, hs, acc, ew, mv;
        logic [4:0] erd, ird, mrd;
        logic [XLEN-1:0] edat;
        #1;
        wb  = RegWriteW && RdW != 0;
        rdy = m_force || !wb;
        stl = (A1 != 0 && m_busy[A1]) || (A2 != 0 && m_busy[A2]) ||
              (issue_valid && issue_rd != 0 && m_busy[issue_rd]) ||
              (issue_valid && m_cnt == MAX_OUT);
        ew = 0; erd = 0; edat = 0;
        if (!m_force && wb) begin
            ew = 1; erd = RdW; edat = ResultW;
        end else if (mdu_valid && rdy && mdu_rd != 0) begin
            ew = 1; erd = mdu_rd; edat = mdu_data;
        end
        chk("pipe_hold", pipe_hold, m_force);
        chk("mdu_ready", mdu_ready, rdy);
        chk("stall_d", stall_d, stl);
        chk("busy_vec", busy_vec, m_busy);
        chk("rf_we", rf_we, ew);
        if (ew) begin
            chk("rf_rd", rf_rd, erd);
            chk("rf_wdata", rf_wdata, edat);
        end
        hs = mdu_valid && rdy; acc = issue_valid && !stl;
        mv = mdu_valid; ird = issue_rd; mrd = mdu_rd;
        @(posedge clk);
        if (hs) begin
            m_busy[mrd] = 0;
            if (m_cnt > 0) m_cnt--;
            if (pend_q.size() > 0) void'(pend_q.pop_front());
        end
        if (acc) begin
            m_busy[ird] = 1;
            m_cnt++;
            pend_q.push_back(ird);
        end
        m_busy[0] = 0;
        if (mv && !rdy) begin
            if (m_wait == STARVE_MAX - 1) begin
                m_force = 1; m_wait = 0;
            end else m_wait++;
        end else begin
            m_force = 0; m_wait = 0;
        end
        hs_last = hs;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock
    task automatic do_reset();
        idle();
        #2 rst = 0;
        #1;
        chk("rst_busy", busy_vec, 0);
        chk("rst_hold", pipe_hold, 0);
        chk("rst_we", rf_we, 0);
        model_clear();
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        rst = 0;
        idle();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1;
        // Reset while x4 is busy
        issue_valid = 1; issue_rd = 4; step();
        idle();
        chk("busy_x4", busy_vec, 32'h10);
        do_reset();
        // WB beats MDU, MDU writes next cycle
        RegWriteW = 1; RdW = 3; ResultW = 'hAA; mdu_valid = 1; mdu_rd = 5; mdu_data = 'hBB;
        #1 chk("arb_rd_wb", rf_rd, 3); chk("arb_dat_wb", rf_wdata, 'hAA); chk("arb_rdy0", mdu_ready, 0);
        step();
        RegWriteW = 0;
        #1 chk("arb_rd_mdu", rf_rd, 5); chk("arb_dat_mdu", rf_wdata, 'hBB); chk("arb_rdy1", mdu_ready, 1);
        step();
        idle();
        // Starvation forces one FORCE cycle
        RegWriteW = 1; RdW = 3; ResultW = 'h33; mdu_valid = 1; mdu_rd = 5; mdu_data = 'h55;
        for (int i = 0; i < STARVE_MAX; i++) begin
            #1 chk("starve_rdy", mdu_ready, 0);
            step();
        end
        #1 chk("force_hold", pipe_hold, 1); chk("force_we", rf_we, 1); chk("force_rd", rf_rd, 5); chk("force_rdy", mdu_ready, 1);
        step();
        mdu_valid = 0;
        #1 chk("force_after_rd", rf_rd, 3); chk("force_after_hold", pipe_hold, 0);
        step();
        idle();
        // RAW hazard on x7
        issue_valid = 1; issue_rd = 7; step();
        idle(); A1 = 7;
        for (int i = 0; i < 3; i++) begin
            #1 chk("raw_stall", stall_d, 1);
            step();
        end
        mdu_valid = 1; mdu_rd = 7; mdu_data = 'h77;
        step();
        mdu_valid = 0;
        #1 chk("raw_release", stall_d, 0);
        step();
        idle();
        // Capacity limit
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1; issue_rd = 5'(r); step();
        end
        issue_rd = 9;
        #1 chk("cap_stall", stall_d, 1);
        step();
        chk("cap_busy", busy_vec, 32'h1E);
        mdu_valid = 1; mdu_rd = 2; mdu_data = 'h22;
        step();
        mdu_valid = 0;
        #1 chk("cap_release", stall_d, 0);
        step();
        idle();
        chk("cap_busy9", busy_vec, 32'h21A);
        do_reset();
        // Edge cases: x0 issue, clear and re-issue of x6
        issue_valid = 1; issue_rd = 0; step();
        idle();
        chk("x0_busy", busy_vec, 0);
        issue_valid = 1; issue_rd = 6; step();
        mdu_valid = 1; mdu_rd = 6; step();
        mdu_valid = 0; step();
        step();
        idle();
        do_reset();
        // Randomized traffic with an MDU that returns issued ops in order
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            RegWriteW = ($urandom_range(0, 3) != 0) || (c % 200 < 40);
            RdW = 5'($urandom_range(0, 31));
            ResultW = $urandom;
            if (hs_last) mdu_valid = 0;
            if (!mdu_valid && pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                mdu_valid = 1; mdu_rd = pend_q[0]; mdu_data = $urandom;
            end
            hs_last = 0;
            issue_valid = $urandom_range(0, 2) == 0;
            issue_rd = 5'($urandom_range(0, 7));
            A1 = 5'($urandom_range(0, 9));
            A2 = 5'($urandom_range(0, 9));
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
Controller for the 32x32 register file's single write port. It arbitrates between the in-order pipeline writeback stage and a long-latency multiply/divide unit (MDU), which returns results through a valid/ready handshake. A 32-entry scoreboard tracks registers with an outstanding MDU result and raises a decode-stage stall on RAW/WAW hazards. Sits between the WB stage, the MDU and the register file write inputs.

Parameters:
XLEN, 32, datapath width of write data.
MAX_OUT, 4, maximum outstanding MDU ops; range 1..31.
STARVE_MAX, 4, consecutive cycles an MDU result may wait before the pipeline is forced to yield; range >=1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
RegWriteW  in  1  WB stage write enable.
RdW  in  5  WB destination register.
ResultW  in  XLEN  WB write data.
mdu_valid  in  1  MDU result available.
mdu_rd  in  5  MDU destination register.
mdu_data  in  XLEN  MDU result.
mdu_ready  out  1  result accepted this cycle when mdu_valid=1.
issue_valid  in  1  decode issuing an MDU op this cycle.
issue_rd  in  5  destination of the issuing MDU op.
A1, A2  in  5 each  decode source registers.
rf_we  out  1  to RegWriteW input of the register file.
rf_rd  out  5  to RdW input of the register file.
rf_wdata  out  XLEN  to ResultW input of the register file.
stall_d  out  1  hold decode/issue.
pipe_hold  out  1  freeze the WB stage for one cycle.
busy_vec  out  32  scoreboard state, for debug.

Behaviour:
- Reset (rst=0, asynchronous): busy_vec=0, outstanding count=0, starve counter=0, FSM=ARB, pipe_hold=0. Combinational outputs follow from this reset state.
- wb_req = RegWriteW && RdW!=0. mdu_req = mdu_valid.
- FSM has 2 states:
  - ARB: WB has priority. mdu_ready = !wb_req. Write-port mux selects WB if wb_req, else MDU if mdu_valid; rf_we=0 otherwise. pipe_hold=0.
  - FORCE: lasts exactly 1 cycle. pipe_hold=1 (registered). WB inputs are ignored; the pipeline re-presents them next cycle. mdu_ready=1, MDU wins the port. Next state is ARB.
- Starve counter:
  - Increments on each cycle with mdu_valid && !mdu_ready; clears on any other cycle.
  - When the counter is STARVE_MAX-1 and the MDU is blocked again, the next state is FORCE and the counter clears.
  - Worst-case MDU wait is STARVE_MAX+1 cycles.
- Write-port mux is combinational, zero latency. The register file commits on the same clk edge.
- MDU write with mdu_rd=0 is accepted (handshake completes) but rf_we=0.
- Scoreboard:
  - Set: busy[issue_rd] sets when issue_valid && !stall_d && issue_rd!=0.
  - Clear: busy[mdu_rd] clears when mdu_valid && mdu_ready.
  - Set and clear of the same register in the same cycle: set wins.
  - Outstanding count: +1 on accepted issue, -1 on MDU handshake. Both in one cycle leaves it unchanged.
- stall_d = (A1!=0 && busy[A1]) || (A2!=0 && busy[A2]) || (issue_valid && issue_rd!=0 && busy[issue_rd]) || (issue_valid && count==MAX_OUT).
- busy[0] is always 0.
- WB and MDU writing the same register in the same cycle cannot occur while the scoreboard is respected. If it does: in ARB the WB write wins and the MDU waits.
- Reset mid-operation discards all pending state. The MDU must be reset by the same rst.

Optional Feature:
RF_SCHED_PERF_EN:
- Defined: adds outputs perf_stall_cnt (32) and perf_force_cnt (32).
  - perf_stall_cnt counts cycles with stall_d=1.
  - perf_force_cnt counts FORCE entries.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports do not exist and no counter logic is generated.

Test Plan:
1. Reset: drive rst=0 mid-run with busy_vec=0x00000010 -> busy_vec=0, pipe_hold=0, rf_we=0 immediately, without waiting for a clock edge.
2. Arbitration: RegWriteW=1, RdW=3, ResultW=0xAA together with mdu_valid=1, mdu_rd=5, mdu_data=0xBB -> cycle 1 writes x3=0xAA with mdu_ready=0. Next cycle with WB idle: x5=0xBB, mdu_ready=1.
3. Starvation (STARVE_MAX=4): WB writes every cycle while mdu_valid=1 -> mdu_ready=0 for 4 cycles, then pipe_hold=1 for one cycle with rf_we=1 and rf_rd=mdu_rd. The WB write lands the following cycle.
4. RAW hazard: issue to x7 accepted, then A1=7 -> stall_d=1 until the MDU handshake on rd=7. stall_d=0 the cycle after.
5. Capacity (MAX_OUT=4): 4 issues to x1..x4, then a 5th issue to x9 -> stall_d=1 and busy_vec=0x0000001E unchanged. One MDU return on x2 -> the issue to x9 is accepted the next cycle.
6. Edge cases: issue to x0 -> busy_vec unchanged. Same-cycle clear and re-issue of x6 -> busy[6] stays 1.
